// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak/SHA3 constants, collector state type and lane helpers
package keccak_pkg;

  localparam int LANE_W     = 64;
  localparam int RATE_LANES = 17;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SKIP,
    HOLD
  } collector_state_e;

  function automatic logic [LANE_W-1:0] lane_bswap(input logic [LANE_W-1:0] lane);
    logic [LANE_W-1:0] r;
    for (int i = 0; i < LANE_W/8; i++) begin
      r[i*8 +: 8] = lane[(LANE_W/8-1-i)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha3_digest_collector_if.sv
// rtl/sha3_digest_collector_if.sv - lane stream in, digest handshake out, for the digest collector
interface sha3_digest_collector_if #(
  parameter int DIGEST_LANES = 4
);

  logic                       lane_valid;
  logic [63:0]                lane_data;
  logic                       hash_done;
  logic [64*DIGEST_LANES-1:0] exp_digest;
  logic                       cmp_en;
  logic [64*DIGEST_LANES-1:0] digest;
  logic                       digest_valid;
  logic                       digest_ready;
  logic                       match;
  logic                       busy;
  logic                       overrun;

  modport slave (
    input  lane_valid, lane_data, hash_done, exp_digest, cmp_en, digest_ready,
    output digest, digest_valid, match, busy, overrun
  );

  modport master (
    output lane_valid, lane_data, hash_done, exp_digest, cmp_en, digest_ready,
    input  digest, digest_valid, match, busy, overrun
  );

endinterface

// File: rtl/digest_cmp_reg.sv
// rtl/digest_cmp_reg.sv - registered full-width digest equality compare, gated by enable
module digest_cmp_reg #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sample,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         match
);

  logic match_q, match_d;

  always_comb begin
    match_d = sample && en && (a == b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  // Re-gate so dropping the enable clears match without waiting a cycle
  assign match = match_q && en;

endmodule

// File: rtl/sha3_digest_collector.sv
// rtl/sha3_digest_collector.sv - captures the first DIGEST_LANES squeeze lanes into a held digest
module sha3_digest_collector
  import keccak_pkg::*;
#(
  parameter int DIGEST_LANES = 4,
  parameter bit BYTE_SWAP    = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  sha3_digest_collector_if.slave   bus
);

  localparam int         DW   = LANE_W * DIGEST_LANES;
  localparam logic [4:0] LAST = 5'(DIGEST_LANES);

  collector_state_e  state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DW-1:0]     digest_q, digest_d;
  logic              digest_valid_q, digest_valid_d;
  logic              overrun_q, overrun_d;

  logic              take;
  logic              fill;
  logic [4:0]        idx;
  logic [4:0]        fill_from;
  logic [LANE_W-1:0] lane_in;

  assign lane_in = BYTE_SWAP ? lane_bswap(bus.lane_data) : bus.lane_data;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    overrun_d      = overrun_q;
    take           = 1'b0;
    fill           = 1'b0;
    idx            = cnt_q;
    fill_from      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.lane_valid) begin
          take = 1'b1;
        end else if (bus.hash_done) begin
          overrun_d = 1'b1;
        end
      end
      COLLECT: begin
        if (bus.lane_valid) begin
          take = 1'b1;
        end else if (bus.hash_done) begin
          fill = 1'b1;
        end
      end
      SKIP: begin
        if (bus.hash_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        digest_valid_d = 1'b1;
        if (digest_valid_q && bus.digest_ready) begin
          digest_valid_d = 1'b0;
          state_d        = IDLE;
          cnt_d          = 5'd0;
          idx            = 5'd0;
          take           = bus.lane_valid;
        end else if (bus.lane_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      for (int k = 0; k < DIGEST_LANES; k++) begin
        if (5'(k) == idx) begin
          digest_d[k*LANE_W +: LANE_W] = lane_in;
        end
      end
      cnt_d     = idx + 5'd1;
      fill_from = idx + 5'd1;
      if (cnt_d == LAST) begin
        state_d = bus.hash_done ? HOLD : SKIP;
      end else if (bus.hash_done) begin
        fill = 1'b1;
      end else begin
        state_d = COLLECT;
      end
    end

    // Stream ended short: lanes never delivered read back as zero
    if (fill) begin
      overrun_d = 1'b1;
      state_d   = HOLD;
      for (int k = 0; k < DIGEST_LANES; k++) begin
        if (5'(k) >= fill_from) begin
          digest_d[k*LANE_W +: LANE_W] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 5'd0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  digest_cmp_reg #(.W(DW)) u_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bus.cmp_en),
    .sample (digest_valid_d),
    .a      (digest_q),
    .b      (bus.exp_digest),
    .match  (bus.match)
  );

  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.busy         = (state_q == COLLECT) || (state_q == SKIP);
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_sha3_digest_collector.sv
// tb/tb_sha3_digest_collector.sv - scoreboard bench for sha3_digest_collector, plain and byte-swapped builds
module tb_sha3_digest_collector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_digest_collector_if #(.DIGEST_LANES(4)) bus0 ();
  sha3_digest_collector_if #(.DIGEST_LANES(4)) bus1 ();

  sha3_digest_collector #(.DIGEST_LANES(4), .BYTE_SWAP(1'b0)) u_plain (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  sha3_digest_collector #(.DIGEST_LANES(4), .BYTE_SWAP(1'b1)) u_swap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus1.lane_valid   = bus0.lane_valid;
  assign bus1.lane_data    = bus0.lane_data;
  assign bus1.hash_done    = bus0.hash_done;
  assign bus1.exp_digest   = bus0.exp_digest;
  assign bus1.cmp_en       = bus0.cmp_en;
  assign bus1.digest_ready = bus0.digest_ready;

  typedef struct {
    logic [255:0] dig;
    logic         m;
    logic         ovr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [255:0] swap_all(input logic [255:0] d);
    logic [255:0] r;
    logic [63:0]  x;
    for (int l = 0; l < 4; l++) begin
      x = d[l*64 +: 64];
      r[l*64 +: 64] = {<<8{x}};
    end
    return r;
  endfunction

  task automatic push(input logic [255:0] d0, input logic [255:0] d1, input logic ovr);
    exp_t e;
    e.ovr = ovr;
    e.dig = d0;
    e.m   = bus0.cmp_en && (d0 == bus0.exp_digest);
    q0.push_back(e);
    e.dig = d1;
    e.m   = bus0.cmp_en && (d1 == bus0.exp_digest);
    q1.push_back(e);
  endtask

  task automatic mon(input int u, input logic v, input logic rdy, input logic [255:0] dig,
                     input logic m, input logic ovr);
    exp_t e;
    if (!v) begin
      check($sformatf("match_when_invalid_u%0d", u), m, 0);
      return;
    end
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_digest_u%0d: got %h required no digest", u, dig);
      return;
    end
    if (u == 0) e = q0[0];
    else        e = q1[0];
    check($sformatf("digest_u%0d", u), dig, e.dig);
    check($sformatf("match_u%0d", u), m, e.m);
    if (rdy) begin
      check($sformatf("overrun_u%0d", u), ovr, e.ovr);
      if (u == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.digest_valid, bus0.digest_ready, bus0.digest, bus0.match, bus0.overrun);
    mon(1, bus1.digest_valid, bus1.digest_ready, bus1.digest, bus1.match, bus1.overrun);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input logic [63:0] d);
    bus0.lane_valid = 1'b1;
    bus0.lane_data  = d;
    tick();
    bus0.lane_valid = 1'b0;
  endtask

  task automatic done_lat();
    bus0.hash_done = 1'b1;
    tick();
    bus0.hash_done = 1'b0;
    check("valid_after_1_cycle", bus0.digest_valid, 0);
    check("busy_after_done", bus0.busy, 0);
    tick();
    check("valid_after_2_cycles", bus0.digest_valid, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digest0"}, bus0.digest, 0);
    check({tag, "_digest1"}, bus1.digest, 0);
    check({tag, "_valid"}, bus0.digest_valid, 0);
    check({tag, "_busy"}, bus0.busy, 0);
    check({tag, "_overrun"}, bus0.overrun, 0);
    check({tag, "_match"}, bus0.match, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] d;
    bus0.lane_valid   = 1'b0;
    bus0.lane_data    = '0;
    bus0.hash_done    = 1'b0;
    bus0.exp_digest   = '0;
    bus0.cmp_en       = 1'b0;
    bus0.digest_ready = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 17-lane squeeze, only lanes 0..3 kept
    d = {64'h3, 64'h2, 64'h1, 64'h0};
    push(d, swap_all(d), 1'b0);
    for (int i = 0; i < 17; i++) begin
      lane(64'(i));
      if (i == 0) check("busy_collect", bus0.busy, 1);
    end
    done_lat();
    tick();
    tick();

    // Compare hit then single-bit miss
    bus0.cmp_en = 1'b1;
    d = {64'h103, 64'h102, 64'h101, 64'h100};
    bus0.exp_digest = d;
    push(d, swap_all(d), 1'b0);
    for (int i = 0; i < 5; i++) lane(64'h100 + 64'(i));
    done_lat();
    tick();
    tick();
    bus0.exp_digest[77] = ~bus0.exp_digest[77];
    push(d, swap_all(d), 1'b0);
    for (int i = 0; i < 5; i++) lane(64'h100 + 64'(i));
    done_lat();
    tick();
    tick();
    bus0.cmp_en = 1'b0;

    // Backpressure for 10 cycles, then accept alongside next lane 0
    bus0.digest_ready = 1'b0;
    d = {64'h23, 64'h22, 64'h21, 64'h20};
    push(d, swap_all(d), 1'b0);
    for (int i = 0; i < 4; i++) lane(64'h20 + 64'(i));
    done_lat();
    repeat (10) tick();
    d = {64'h33, 64'h32, 64'h31, 64'h30};
    push(d, swap_all(d), 1'b0);
    bus0.digest_ready = 1'b1;
    lane(64'h30);
    check("busy_back_to_back", bus0.busy, 1);
    for (int i = 1; i < 4; i++) lane(64'h30 + 64'(i));
    done_lat();
    tick();
    tick();

    // Lane arriving during HOLD is dropped and flags overrun
    bus0.digest_ready = 1'b0;
    d = {64'h43, 64'h42, 64'h41, 64'h40};
    push(d, swap_all(d), 1'b1);
    for (int i = 0; i < 4; i++) lane(64'h40 + 64'(i));
    done_lat();
    lane(64'hDEAD);
    check("overrun_hold_drop", bus0.overrun, 1);
    tick();
    bus0.digest_ready = 1'b1;
    tick();
    tick();

    // Reset mid-collection
    lane(64'h50);
    lane(64'h51);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    d = {64'h63, 64'h62, 64'h61, 64'h60};
    push(d, swap_all(d), 1'b0);
    for (int i = 0; i < 4; i++) lane(64'h60 + 64'(i));
    done_lat();
    tick();
    tick();

    // Short stream: missing lanes zero-filled
    d = {64'h0, 64'h0, 64'hB, 64'hA};
    push(d, swap_all(d), 1'b1);
    lane(64'hA);
    lane(64'hB);
    done_lat();
    check("overrun_short", bus0.overrun, 1);
    tick();
    tick();

    // Byte-swap hand vector
    push({192'h0, 64'h0123456789ABCDEF}, {192'h0, 64'hEFCDAB8967452301}, 1'b1);
    lane(64'h0123456789ABCDEF);
    done_lat();
    tick();
    tick();

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    check("queue0_drained", 256'(q0.size()), 0);
    check("queue1_drained", 256'(q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_digest_collector.md
Name: sha3_digest_collector

Overview:
- Sits directly downstream of the SHA3 core. It consumes the serialised 64-bit lane stream the core emits after the final permutation.
- Keeps the first DIGEST_LANES lanes, byte-orders them, and assembles a parallel digest.
- Presents the digest to the host on a valid/ready handshake.
- Optionally compares the digest against an expected value for self-test.

Parameters:
- DIGEST_LANES, 4, number of 64-bit lanes kept (4 = SHA3-256, range 1..17).
- BYTE_SWAP, 1, 1 = reverse byte order within each lane on capture, 0 = pass through.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- lane_valid  in  1  qualifies lane_data; one lane per asserted cycle, lane 0 first.
- lane_data  in  64  lane from the core's parallel_serial stage (core data_out).
- hash_done  in  1  single-cycle pulse from the core's finish_hash, marking the end of the squeeze stream.
- exp_digest  in  64*DIGEST_LANES  expected digest, sampled when the digest is presented.
- cmp_en  in  1  enables comparison.
- digest  out  64*DIGEST_LANES  assembled digest; lane k occupies bits [64k+63:64k].
- digest_valid  out  1  digest available.
- digest_ready  in  1  host accepts the digest.
- match  out  1  digest == exp_digest; valid only while digest_valid && cmp_en.
- busy  out  1  collection in progress.
- overrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, lane counter=0, digest=0, digest_valid=0, match=0, busy=0, overrun=0. Reset mid-collection or mid-hold discards all partial data.
- Lane capture: lane k is stored into digest slice k, byte-swapped if BYTE_SWAP=1, in the same clock edge it is seen. The counter is 5 bits and saturates at DIGEST_LANES.
- IDLE:
  - lane_valid -> capture lane 0, cnt=1, go to COLLECT, busy=1.
  - If DIGEST_LANES==1 -> go to SKIP instead.
  - hash_done with no lanes received -> stay IDLE and set overrun (empty hash).
- COLLECT:
  - Each lane_valid captures lane cnt and increments cnt.
  - When the lane with index DIGEST_LANES-1 is captured -> go to SKIP.
  - hash_done before cnt reaches DIGEST_LANES -> set overrun, zero-fill the missing lanes, go to HOLD.
- SKIP:
  - Lanes beyond DIGEST_LANES are discarded.
  - hash_done -> go to HOLD, busy=0, digest_valid=1 on the next cycle.
  - If hash_done coincides with the final kept lane, the lane is captured and the block goes straight to HOLD.
- HOLD:
  - digest_valid=1; digest is stable until accepted.
  - match is registered one cycle after entering HOLD from exp_digest (1-cycle compare pipeline). digest_valid therefore rises together with the registered match, so entry-to-valid latency is 1 cycle.
  - digest_valid && digest_ready -> digest_valid=0, go to IDLE, cnt=0. digest is retained, not cleared.
  - lane_valid during HOLD -> lane dropped, overrun=1.
  - lane_valid in the same cycle as the accepting handshake -> the lane is captured as lane 0 of the next hash and the state moves to COLLECT (back-to-back support).
- Latency: digest_valid asserts 2 cycles after the hash_done edge (the SKIP->HOLD transition plus the registered compare).
- match=0 whenever cmp_en=0 or digest_valid=0.
- Widths: no arithmetic beyond the counter. Comparison is full-width equality.

Decomposition:
- keccak_pkg gains:
  - LANE_W=64;
  - RATE_LANES=17;
  - a typedef for the collector state enum {IDLE, COLLECT, SKIP, HOLD};
  - a function lane_bswap(logic [63:0]) returning the byte-reversed lane.
- One natural sub-module: digest_cmp_reg, the registered equality compare with its enable gating, so the same block can be reused for other digest sizes.
- Everything else stays in this module.

Test Plan:
- Basic SHA3-256 (DIGEST_LANES=4, BYTE_SWAP=0):
  - Stimulus: 17 lanes 0x0..0x10, then hash_done.
  - Required: digest = {64'h3, 64'h2, 64'h1, 64'h0}, digest_valid exactly 2 cycles after hash_done, busy low, overrun=0.
- Byte swap (BYTE_SWAP=1):
  - Stimulus: lane 0 = 64'h0123456789ABCDEF.
  - Required: digest[63:0] = 64'hEFCDAB8967452301.
- Compare:
  - Stimulus: cmp_en=1, exp_digest equal to the stream digest.
  - Required: match=1 with digest_valid.
  - Then flip one bit of exp_digest on the next hash -> match=0.
- Backpressure and back-to-back:
  - Stimulus: hold digest_ready=0 for 10 cycles, then raise it in the same cycle as lane 0 of the next hash.
  - Required: digest stable throughout the hold; the new lane 0 is captured; the next digest is correct; overrun=0.
- Short stream and overrun:
  - Stimulus: hash_done after only 2 lanes (0xA, 0xB).
  - Required: overrun=1, digest = {0, 0, 0xB, 0xA}, digest_valid asserted.
  - Separately, lane_valid during HOLD -> overrun=1 and the held digest is unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 after 2 lanes have been captured.
  - Required: all outputs return to 0 asynchronously; the next full stream produces the correct digest.
